// File: rtl/shoelace_pkg.sv
// Shared constants for the shoelace lap sequencer: FSM encoding and synchronizer depth.
package shoelace_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam int SYNC_DEPTH      = 2;
  localparam int MIN_LAP_LATENCY = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing the ring tail into the clk domain.
module sync2
  import shoelace_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_DEPTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_DEPTH-1];

endmodule

// File: rtl/shoelace_sequencer.sv
// Lap controller for a co-simulated inverter ring: toggles the chain head, times each
// round trip back from the tail, and tracks per-lap, min and max latency.
module shoelace_sequencer
  import shoelace_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 16,
  parameter int LAPS_W     = 8,
  parameter int TIMEOUT    = 1000
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LAPS_W-1:0] num_laps,
  input  logic              chain_out,
  output logic              launch,
  output logic              busy,
  output logic              done,
  output logic              lap_valid,
  output logic [CNT_W-1:0]  lap_latency,
  output logic [LAPS_W-1:0] lap_count,
  output logic [CNT_W-1:0]  min_latency,
  output logic [CNT_W-1:0]  max_latency,
  output logic              error_timeout
);

  localparam logic             STAGE_PARITY = ((NUM_STAGES % 2) != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_count;
  logic [LAPS_W-1:0] r_laps;
  logic              r_launch;
  logic              r_busy;
  logic              r_done;
  logic              r_lapValid;
  logic [CNT_W-1:0]  r_lapLatency;
  logic [LAPS_W-1:0] r_lapCount;
  logic [CNT_W-1:0]  r_minLatency;
  logic [CNT_W-1:0]  r_maxLatency;
  logic              r_errorTimeout;

  logic              w_tailS;
  logic              w_match;
  logic              w_startOk;
  logic [CNT_W-1:0]  w_cntNext;
  logic [LAPS_W-1:0] w_lapsNext;

  sync2 u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (chain_out),
    .o_sync  (w_tailS)
  );

  // r_launch already holds the post-toggle value while a lap is in flight.
  assign w_match    = (w_tailS == (r_launch ^ STAGE_PARITY));
  assign w_startOk  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_cntNext  = (&r_count) ? r_count : r_count + CNT_W'(1);
  assign w_lapsNext = r_lapCount + LAPS_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_laps         <= '0;
      r_launch       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_lapValid     <= 1'b0;
      r_lapLatency   <= '0;
      r_lapCount     <= '0;
      r_minLatency   <= '1;
      r_maxLatency   <= '0;
      r_errorTimeout <= 1'b0;
    end else begin
      r_lapValid <= 1'b0;
      r_done     <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_startOk) begin
            r_laps         <= num_laps;
            r_lapCount     <= '0;
            r_maxLatency   <= '0;
            r_minLatency   <= '1;
            r_errorTimeout <= 1'b0;
            r_count        <= '0;
            r_busy         <= 1'b1;
            r_state        <= ST_ARM;
          end else if (r_state == ST_DONE) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ARM: begin
          if (w_match) begin
            if (r_laps == '0) begin
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_launch <= ~r_launch;
              r_count  <= '0;
              r_state  <= ST_WAIT;
            end
          end else if (w_cntNext >= TIMEOUT_C) begin
            r_errorTimeout <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= ST_ERR;
          end else begin
            r_count <= w_cntNext;
          end
        end
        ST_WAIT: begin
          // A match on the timeout cycle still counts as a good lap.
          if (w_match) begin
            r_lapValid   <= 1'b1;
            r_lapLatency <= w_cntNext;
            r_lapCount   <= w_lapsNext;
            if (w_cntNext < r_minLatency) r_minLatency <= w_cntNext;
            if (w_cntNext > r_maxLatency) r_maxLatency <= w_cntNext;
            if (w_lapsNext == r_laps) begin
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_launch <= ~r_launch;
              r_count  <= '0;
            end
          end else if (w_cntNext >= TIMEOUT_C) begin
            r_errorTimeout <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= ST_ERR;
          end else begin
            r_count <= w_cntNext;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign launch        = r_launch;
  assign busy          = r_busy;
  assign done          = r_done;
  assign lap_valid     = r_lapValid;
  assign lap_latency   = r_lapLatency;
  assign lap_count     = r_lapCount;
  assign min_latency   = r_minLatency;
  assign max_latency   = r_maxLatency;
  assign error_timeout = r_errorTimeout;

endmodule

// File: tb/tb_shoelace_sequencer.sv
// Scoreboard bench for shoelace_sequencer: a behavioural ring with selectable delay,
// expected lap/done/error events queued at stimulus time and popped by a monitor.
module tb_shoelace_sequencer;
  import shoelace_pkg::*;

  localparam int NS = 5;
  localparam int CW = 16;
  localparam int LW = 8;
  localparam int TO = 20;

  localparam int K_LAP  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] num_laps = '0;
  logic          chain_out;
  logic          launch;
  logic          busy;
  logic          done;
  logic          lap_valid;
  logic [CW-1:0] lap_latency;
  logic [LW-1:0] lap_count;
  logic [CW-1:0] min_latency;
  logic [CW-1:0] max_latency;
  logic          error_timeout;

  int passCount = 0;
  int checkCount = 0;

  // Ring model: inverting chain (odd stage count) with an optional whole-cycle delay.
  int          ringDelay = 0;
  logic        stuckMode = 1'b0;
  logic        stuckVal = 1'b0;
  logic [15:0] ringPipe = '1;
  int          modelLaunch = 0;

  typedef struct {
    int kind;
    int lat;
    int cnt;
    int mn;
    int mx;
    int launchEnd;
  } expT;

  expT expQ[$];

  shoelace_sequencer #(
    .NUM_STAGES (NS),
    .CNT_W      (CW),
    .LAPS_W     (LW),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_laps      (num_laps),
    .chain_out     (chain_out),
    .launch        (launch),
    .busy          (busy),
    .done          (done),
    .lap_valid     (lap_valid),
    .lap_latency   (lap_latency),
    .lap_count     (lap_count),
    .min_latency   (min_latency),
    .max_latency   (max_latency),
    .error_timeout (error_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ringPipe <= {ringPipe[14:0], ~launch};

  always_comb begin
    chain_out = 1'b0;
    if (stuckMode) chain_out = stuckVal;
    else if (ringDelay == 0) chain_out = ~launch;
    else chain_out = ringPipe[ringDelay-1];
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pops one expected event whenever the DUT presents lap_valid, done or a new error.
  int   cyc = 0;
  int   toggleCyc = 0;
  logic prevLaunch = 1'b0;
  logic prevErr = 1'b0;

  always @(negedge clk) begin
    expT e;
    cyc++;
    if (launch !== prevLaunch) toggleCyc = cyc;
    prevLaunch = launch;
    if (!reset) begin
      if (lap_valid) begin
        checkOutput("lap_expected", (expQ.size() > 0 && expQ[0].kind == K_LAP), 1);
        if (expQ.size() > 0 && expQ[0].kind == K_LAP) begin
          e = expQ.pop_front();
          checkOutput("lap_latency", lap_latency, e.lat);
          checkOutput("lap_count", lap_count, e.cnt);
          checkOutput("min_latency", min_latency, e.mn);
          checkOutput("max_latency", max_latency, e.mx);
        end
      end
      if (done) begin
        checkOutput("done_expected", (expQ.size() > 0 && expQ[0].kind == K_DONE), 1);
        if (expQ.size() > 0 && expQ[0].kind == K_DONE) begin
          e = expQ.pop_front();
          checkOutput("done_lap_count", lap_count, e.cnt);
          checkOutput("done_launch", launch, e.launchEnd);
          checkOutput("done_busy", busy, 0);
          checkOutput("done_error", error_timeout, 0);
        end
      end
      if (error_timeout && !prevErr) begin
        checkOutput("err_expected", (expQ.size() > 0 && expQ[0].kind == K_ERR), 1);
        if (expQ.size() > 0 && expQ[0].kind == K_ERR) begin
          e = expQ.pop_front();
          checkOutput("err_busy", busy, 0);
          checkOutput("err_wait_cycles", cyc - toggleCyc, TO);
        end
      end
    end
    prevErr = error_timeout;
  end

  task automatic waitDrain();
    int budget = 0;
    while (expQ.size() > 0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("drain", expQ.size(), 0);
    expQ.delete();
    @(negedge clk);
  endtask

  // Every lap of a fixed-delay ring takes the minimum latency plus the ring delay.
  task automatic pushRunModel(input int n, input int d);
    int lat = MIN_LAP_LATENCY + d;
    int runMin = 'hFFFF;
    int runMax = 0;
    expT e;
    for (int k = 1; k <= n; k++) begin
      runMin = (lat < runMin) ? lat : runMin;
      runMax = (lat > runMax) ? lat : runMax;
      e = '{kind: K_LAP, lat: lat, cnt: k, mn: runMin, mx: runMax, launchEnd: 0};
      expQ.push_back(e);
    end
    modelLaunch = modelLaunch ^ (n % 2);
    e = '{kind: K_DONE, lat: 0, cnt: n, mn: 0, mx: 0, launchEnd: modelLaunch};
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int n, input int d, input bit poke);
    ringDelay = d;
    repeat (d + 4) @(negedge clk);
    pushRunModel(n, d);
    num_laps = LW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("err_clear_on_start", error_timeout, 0);
    if (poke && n > 0) begin
      @(negedge clk);
      start = 1'b1;
      num_laps = LW'(n + 1);
      @(negedge clk);
      start = 1'b0;
    end
    waitDrain();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expT e;
    int budget;
    int n;
    int d;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_launch", launch, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_lap_valid", lap_valid, 0);
    checkOutput("rst_lap_latency", lap_latency, 0);
    checkOutput("rst_lap_count", lap_count, 0);
    checkOutput("rst_min", min_latency, 'hFFFF);
    checkOutput("rst_max", max_latency, 0);
    checkOutput("rst_error", error_timeout, 0);

    applyStimulus(3, 0, 1'b0);
    applyStimulus(2, 4, 1'b1);
    applyStimulus(0, 0, 1'b0);

    // Tail stuck low: the settle check passes, the lap never returns.
    stuckVal = 1'b0;
    stuckMode = 1'b1;
    repeat (4) @(negedge clk);
    e = '{kind: K_ERR, lat: 0, cnt: 0, mn: 0, mx: 0, launchEnd: 0};
    expQ.push_back(e);
    num_laps = LW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("stuck_busy", busy, 1);
    waitDrain();
    modelLaunch = modelLaunch ^ 1;
    repeat (5) @(negedge clk);
    checkOutput("stuck_err_sticky", error_timeout, 1);
    stuckMode = 1'b0;
    applyStimulus(1, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(0, 5);
      d = $urandom_range(0, 6);
      applyStimulus(n, d, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of lap 2 of a 4-lap run.
    ringDelay = 2;
    repeat (6) @(negedge clk);
    pushRunModel(4, 2);
    num_laps = LW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    budget = 0;
    while (lap_count != LW'(1) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("reach_lap1", lap_count, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_launch", launch, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_lap_count", lap_count, 0);
    checkOutput("midrst_min", min_latency, 'hFFFF);
    checkOutput("midrst_max", max_latency, 0);
    reset = 1'b0;
    expQ.delete();
    modelLaunch = 0;
    applyStimulus(4, 2, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/shoelace_sequencer.md
# shoelace_sequencer

Synchronous lap controller for a co-simulated inverter ring. It drives the head net of a chain of inverting stages, some in Verilog and some in prsim, and waits for each transition to propagate back from the tail. It counts clock cycles per lap and reports per-lap, min and max latency, stopping with an error on timeout. It sits in the bench top level, replacing the free-running clock generator as the stimulus source for the chain.

## Interface
- NUM_STAGES, 5: inverting stages between `launch` and `chain_out`; bit 0 sets the expected tail polarity.
- CNT_W, 16: width of the latency counter and latency outputs.
- LAPS_W, 8: width of the lap-count request and counter.
- TIMEOUT, 1000: cycles allowed per settle or lap before error; must be less than 2^CNT_W.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; ignored unless in IDLE, DONE or ERR.
- num_laps  in  LAPS_W  laps to run, sampled when `start` is accepted.
- chain_out  in  1  tail of the ring; asynchronous to `clk`.
- launch  out  1  registered drive into the chain head.
- busy  out  1  high in ARM and WAIT.
- done  out  1  one-cycle pulse when all laps complete.
- lap_valid  out  1  one-cycle pulse per completed lap.
- lap_latency  out  CNT_W  latency of the lap just completed; holds its value between pulses.
- lap_count  out  LAPS_W  laps completed in the current run.
- min_latency  out  CNT_W  minimum lap latency this run.
- max_latency  out  CNT_W  maximum lap latency this run.
- error_timeout  out  1  sticky until `reset` or an accepted `start`.

## Operation
- Definitions:
  - `chain_out` passes through a 2-flop synchronizer; its output is `tail_s`.
  - `expected = launch ^ NUM_STAGES[0]`.
- States: IDLE, ARM, WAIT, DONE, ERR.
- IDLE, on `start`:
  - latch `num_laps`; clear `lap_count`, `max_latency` and `error_timeout`;
  - set `min_latency` to all-ones; clear the counter;
  - go to ARM.
- ARM (settle check):
  - counter increments each cycle;
  - if `tail_s == expected`: if the latched laps value is 0, go to DONE; otherwise toggle `launch`, clear the counter and go to WAIT;
  - if the counter reaches TIMEOUT first, go to ERR.
- WAIT:
  - counter increments each cycle;
  - when `tail_s == expected`, using the updated `launch` value:
    - pulse `lap_valid`;
    - `lap_latency` = counter + 1;
    - update min/max with that value; increment `lap_count`;
  - if `lap_count` then equals the latched laps value, go to DONE;
  - otherwise toggle `launch` on the same edge, clear the counter and stay in WAIT (back-to-back laps).
  - If the counter reaches TIMEOUT first, set `error_timeout` and go to ERR; `launch` holds.
- DONE: `done` is high for exactly one cycle, then the FSM goes to IDLE. A `start` in DONE is accepted as in IDLE.
- ERR: holds until `start`, which behaves as in IDLE, or `reset`.
- The counter saturates and never wraps. Detection is evaluated before timeout: a match in the same cycle that TIMEOUT is reached is a good lap.
- Reset (including mid-lap) forces:
  - state IDLE; synchronizer flops 0;
  - `launch`, `busy`, `done`, `lap_valid`, `lap_latency`, `lap_count`, `max_latency`, `error_timeout` all 0;
  - `min_latency` all-ones.

## Timing
- Launch edge L toggles `launch`. With a zero-delay ring, `tail_s` updates at L+2, and `lap_valid` plus the next toggle occur at edge L+3, so `lap_latency` = 3.
- Minimum reported latency is 3. Each full cycle of ring delay adds 1.
- `start` to first `launch` toggle: 1 cycle if the ring is already settled (ARM lasts one cycle).
- Last `lap_valid` and `done` are one cycle apart: `lap_valid` at edge D, `done` high from D+1 to D+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `shoelace_pkg`:
  - FSM state encoding (IDLE=0, ARM=1, WAIT=2, DONE=3, ERR=4);
  - `SYNC_DEPTH = 2`;
  - `MIN_LAP_LATENCY = 3`.
- One sub-module, `sync2`: a 2-flop synchronizer with synchronous active-high reset to 0. It is instantiated once, for `chain_out`.
- Everything else (FSM, counter, lap bookkeeping) lives in `shoelace_sequencer`.

## Test plan
- Zero-delay 5-stage ring, `num_laps`=3, `start` → three `lap_valid` pulses, each with `lap_latency`=3; min=max=3; `lap_count`=3; one `done` pulse; `launch` ends at 1.
- Ring with 4-cycle tail delay, `num_laps`=2 → `lap_latency`=7 twice; min=max=7.
- Tail stuck at 0 with NUM_STAGES=5 and TIMEOUT=20 → settle passes, the lap times out after 20 WAIT cycles, `error_timeout`=1, `busy`=0, no `done`; a following `start` clears the error.
- `num_laps`=0 → `done` after ARM, no `launch` toggle, `lap_count`=0.
- `reset` asserted mid-WAIT on lap 2 of 4 → next cycle: `launch`=0, state IDLE, `lap_count`=0, `min_latency`=all-ones; a new `start` runs a clean 4-lap sequence.
- `start` pulsed during WAIT → ignored; the run completes with its original `num_laps`.
